fb_scan_ctrl: RTL and testbench
===============================

Name: fb_scan_ctrl

Overview:
Scan sequencer for the double-buffered LED framebuffer. It walks the display-side read port row by row and column by column, and serialises the returned pixels to the HUB-style panel with shift, latch and output-enable timing. It owns the `display` buffer-select bit and swaps buffers only at a frame boundary, under a req/ack handshake with the writer. It sits between the framebuffer's display port and the panel pins, with `dispclk` tied to `clk`.

Parameters:
COLS, 64, pixels shifted per row (power of 2, ≤64)
ROWS, 8, scan rows per frame (power of 2, ≤8)
PLANES, 8, colour bit-planes (only with BCM_EN)
BASE_DWELL, 16, OE-low cycles for plane 0 (must be ≥1)

Ports:
clk  in  1  single clock; also drives framebuffer dispclk
reset  in  1  asynchronous, active-high
enable  in  1  scanning allowed
swap_req  in  1  writer requests buffer swap (level)
swap_ack  out  1  one-cycle pulse when swap performed
display  out  1  buffer select to framebuffer
row  out  3  framebuffer read row
col  out  6  framebuffer read column
red, green, blue  in  8 each  framebuffer read data, valid 1 cycle after row/col
panel_r, panel_g, panel_b  out  1 each  serial pixel data
panel_clk  out  1  panel shift clock
panel_lat  out  1  panel latch strobe
panel_oe_n  out  1  panel output enable, active low
panel_row  out  3  row address driven to the panel
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async, any state): state IDLE; display=0; panel_oe_n=1; all other outputs 0; all counters 0.
- States: IDLE, SHIFT, LATCH, DWELL.
- Scan order: row (outer), then plane (inner). Each (row, plane) pass runs SHIFT → LATCH → DWELL.
- IDLE:
  - If swap_req=1: toggle display and pulse swap_ack in the same cycle.
  - Else if enable=1: pulse frame_start, then SHIFT next cycle with row=0, plane=0.
  - swap has priority; a start is deferred to the following cycle.
- SHIFT: 2*COLS cycles. Pixel k owns cycles 2k and 2k+1.
  - col=k during both cycles of pixel k.
  - panel_r/g/b <= red/green/blue[plane], registered at the end of cycle 2k+1.
  - panel_clk=1 during cycle 2k+2: that is, in the next slot, or in LATCH cycle 0 for the last pixel.
  - panel_oe_n=1 throughout.
- LATCH: 2 cycles, panel_oe_n=1.
  - Cycle 0: panel_clk=1.
  - Cycle 1: panel_lat=1, and panel_row<=row.
- DWELL: panel_oe_n=0 for BASE_DWELL<<plane cycles (BASE_DWELL without BCM_EN), then advance.
- Advance after DWELL:
  - Next plane.
  - Or plane wraps to 0 and row+1.
  - After the last row: end of frame.
- End of frame:
  - If swap_req=1: toggle display, pulse swap_ack, and restart with row=0 with no extra cycle.
  - If enable=0: go to IDLE.
  - Otherwise pulse frame_start and start the next frame.
  - A swap and a restart in the same cycle are allowed.
- Swap rules:
  - display never changes outside IDLE or the end-of-frame cycle, so no frame mixes buffers.
  - swap_req must drop within one cycle after swap_ack; a held request swaps once per frame boundary.
- enable deasserted mid-frame: the current frame completes, then IDLE.
- Counter widths: col log2(COLS), row log2(ROWS), dwell counter 16 bits. Counters wrap only through the explicit transitions above.

Optional Feature:
FB_SCAN_BCM_EN
- Defined: binary-coded modulation over PLANES planes, plane p dwell = BASE_DWELL<<p, data bit = colour[p].
- Undefined: single plane using colour bit 7, dwell BASE_DWELL, plane counter removed.

Decomposition:
- Package fb_scan_pkg: state enum (IDLE/SHIFT/LATCH/DWELL), LATCH_CYCLES=2, dwell counter width constant.
- Sub-module fb_dwell_timer: loadable down-counter taking plane and BASE_DWELL, producing a done pulse. Holds the shift-based dwell computation.

Test Plan:
Common parameters: COLS=4, ROWS=2, BASE_DWELL=2, BCM off.
- Reset and start: release reset with enable=1.
  - frame_start pulses the cycle after IDLE.
  - panel_oe_n=1 for 10 cycles (SHIFT+LATCH), then 0 for 2 cycles.
  - Frame length 24 cycles.
- Pixel path: red[7] pattern 1,0,1,1 for cols 0..3.
  - panel_r sampled on panel_clk high reads 1,0,1,1.
  - Exactly 4 panel_clk pulses, then 1 panel_lat pulse per row.
- Swap at boundary: assert swap_req mid-frame.
  - display toggles and swap_ack pulses only at the cycle after the last DWELL.
  - The next frame reads the other buffer.
- Swap in IDLE with enable=0: swap_req pulse → display toggles within 1 cycle, swap_ack pulses once.
- Async reset mid-DWELL: panel_oe_n goes to 1 and display to 0 immediately, without waiting for a clock edge.
- BCM: with BCM_EN, PLANES=8, BASE_DWELL=1 → OE-low run lengths per row are 1,2,4,…,128; panel data bit follows plane index.

Source files
------------

// File: rtl/fb_scan_ctrl_pkg.sv
// fb_scan_pkg: shared definitions for the framebuffer scan sequencer.
//   scan_state_t  - sequencer states (IDLE / SHIFT / LATCH / DWELL)
//   LATCH_CYCLES  - cycles spent in LATCH (clock tail, then latch strobe)
//   DWELL_W       - width of the output-enable dwell counter
package fb_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } scan_state_t;

    localparam int LATCH_CYCLES = 2;
    localparam int DWELL_W      = 16;

endpackage

// File: rtl/fb_scan_ctrl_if.sv
// fb_scan_ctrl_if: framebuffer display-port and buffer-swap handshake bundle.
//   display          - buffer select toward the framebuffer
//   row, col         - framebuffer read address
//   red, green, blue - read data, valid one cycle after row/col
//   swap_req         - writer's level request for a buffer swap
//   swap_ack         - one-cycle pulse when the swap is performed
// Modports: master = scan sequencer, slave = framebuffer/writer side.
interface fb_scan_ctrl_if;

    logic       display;
    logic [2:0] row;
    logic [5:0] col;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       swap_req;
    logic       swap_ack;

    modport master (
        output display, row, col, swap_ack,
        input  red, green, blue, swap_req
    );

    modport slave (
        input  display, row, col, swap_ack,
        output red, green, blue, swap_req
    );

endinterface

// File: rtl/fb_scan_ctrl_dwell_timer.sv
// fb_dwell_timer: loadable down-counter timing the output-enable dwell.
//   clk, reset - clock, asynchronous active-high reset
//   load_i     - start a dwell of BASE_DWELL << plane_i cycles
//   plane_i    - bit-plane index selecting the dwell length
//   done_o     - one-cycle pulse in the final cycle of the dwell
module fb_dwell_timer
    import fb_scan_pkg::*;
#(
    parameter int BASE_DWELL = 16,
    parameter int PLANE_W    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [PLANE_W-1:0] plane_i,
    output logic               done_o
);

    logic [DWELL_W-1:0] dwell_len;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               armed_q, armed_d;

    assign dwell_len = DWELL_W'(BASE_DWELL) << plane_i;

    // Loaded with length-1 so that done lands in the last dwell cycle.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load_i) begin
            cnt_d   = dwell_len - DWELL_W'(1);
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) armed_d = 1'b0;
            else             cnt_d   = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/fb_scan_ctrl.sv
// fb_scan_ctrl: scan sequencer for the double-buffered LED framebuffer.
// Walks the display read port row by row, serialises pixels to a HUB-style
// panel (shift / latch / output-enable dwell) and owns the display buffer
// select, swapping only in IDLE or at a frame boundary.
// Ports:
//   clk, reset    - clock (also framebuffer dispclk), async active-high reset
//   enable        - scanning allowed; sampled at frame boundaries and in IDLE
//   fb            - fb_scan_ctrl_if.master: read port + swap handshake
//   panel_r/g/b   - serial pixel data
//   panel_clk     - panel shift clock
//   panel_lat     - panel latch strobe
//   panel_oe_n    - panel output enable, active low
//   panel_row     - row address driven to the panel
//   frame_start   - one-cycle pulse at the start of each frame
// Build option: FB_SCAN_BCM_EN enables binary-coded modulation over PLANES
// planes (dwell BASE_DWELL << plane, data bit = plane); otherwise a single
// plane using colour bit 7 with dwell BASE_DWELL.
module fb_scan_ctrl
    import fb_scan_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int ROWS       = 8,
    parameter int PLANES     = 8,
    parameter int BASE_DWELL = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    fb_scan_ctrl_if.master fb,
    output logic          panel_r,
    output logic          panel_g,
    output logic          panel_b,
    output logic          panel_clk,
    output logic          panel_lat,
    output logic          panel_oe_n,
    output logic [2:0]    panel_row,
    output logic          frame_start
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LW = $clog2(LATCH_CYCLES);

    localparam logic [CW-1:0] LAST_COL     = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW     = RW'(ROWS - 1);
    localparam logic [LW-1:0] LATCH_STROBE = LW'(LATCH_CYCLES - 2);
    localparam logic [LW-1:0] LATCH_LAST   = LW'(LATCH_CYCLES - 1);

`ifdef FB_SCAN_BCM_EN
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);
`else
    localparam int PW = 1;
    localparam int unused_planes = PLANES;
`endif

    scan_state_t   state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          phase_q;
    logic [LW-1:0] latch_q;
    logic          display_q;
    logic          swap_ack_q;
    logic          frame_start_q;
    logic [2:0]    panel_rgb_q;
    logic          panel_clk_q;
    logic          panel_lat_q;
    logic          panel_oe_n_q;
    logic [2:0]    panel_row_q;

    logic [2:0]    pix_bits;
    logic          last_plane;
    logic [PW-1:0] timer_plane;
    logic          timer_load;
    logic          dwell_done;
    logic          swap_go;
    logic          unused_colour;

`ifdef FB_SCAN_BCM_EN
    logic [PW-1:0] plane_q;

    assign pix_bits    = {fb.red[plane_q], fb.green[plane_q], fb.blue[plane_q]};
    assign last_plane  = (plane_q == LAST_PLANE);
    assign timer_plane = plane_q;
`else
    assign pix_bits    = {fb.red[7], fb.green[7], fb.blue[7]};
    assign last_plane  = 1'b1;
    assign timer_plane = '0;
`endif

    assign unused_colour = ^{fb.red, fb.green, fb.blue};

    // The writer may still hold swap_req during the ack cycle; ignore it there.
    assign swap_go    = fb.swap_req && !swap_ack_q;
    assign timer_load = (state_q == ST_LATCH) && (latch_q == LATCH_LAST);

    fb_dwell_timer #(
        .BASE_DWELL (BASE_DWELL),
        .PLANE_W    (PW)
    ) u_dwell (
        .clk     (clk),
        .reset   (reset),
        .load_i  (timer_load),
        .plane_i (timer_plane),
        .done_o  (dwell_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            phase_q       <= 1'b0;
            latch_q       <= '0;
            display_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            panel_rgb_q   <= '0;
            panel_clk_q   <= 1'b0;
            panel_lat_q   <= 1'b0;
            panel_oe_n_q  <= 1'b1;
            panel_row_q   <= '0;
`ifdef FB_SCAN_BCM_EN
            plane_q       <= '0;
`endif
        end else begin
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            panel_clk_q   <= 1'b0;
            panel_lat_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (swap_go) begin
                        display_q  <= ~display_q;
                        swap_ack_q <= 1'b1;
                    end else if (enable) begin
                        frame_start_q <= 1'b1;
                        state_q       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Second half of each pixel: capture data and raise the
                    // shift clock for the following cycle.
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        panel_clk_q <= 1'b1;
                        panel_rgb_q <= pix_bits;
                        if (col_q == LAST_COL) begin
                            col_q   <= '0;
                            state_q <= ST_LATCH;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_q == LATCH_STROBE) begin
                        panel_lat_q <= 1'b1;
                        panel_row_q <= 3'(row_q);
                    end
                    if (latch_q == LATCH_LAST) begin
                        latch_q      <= '0;
                        panel_oe_n_q <= 1'b0;
                        state_q      <= ST_DWELL;
                    end else begin
                        latch_q <= latch_q + LW'(1);
                    end
                end
                ST_DWELL: begin
                    if (dwell_done) begin
                        panel_oe_n_q <= 1'b1;
                        state_q      <= ST_SHIFT;
`ifdef FB_SCAN_BCM_EN
                        plane_q <= last_plane ? '0 : plane_q + PW'(1);
`endif
                        if (last_plane) begin
                            if (row_q != LAST_ROW) begin
                                row_q <= row_q + RW'(1);
                            end else begin
                                // End of frame: swap and restart may coincide.
                                row_q <= '0;
                                if (swap_go) begin
                                    display_q  <= ~display_q;
                                    swap_ack_q <= 1'b1;
                                end
                                if (enable) frame_start_q <= 1'b1;
                                else        state_q       <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fb.display  = display_q;
    assign fb.row      = 3'(row_q);
    assign fb.col      = 6'(col_q);
    assign fb.swap_ack = swap_ack_q;

    assign panel_r     = panel_rgb_q[2];
    assign panel_g     = panel_rgb_q[1];
    assign panel_b     = panel_rgb_q[0];
    assign panel_clk   = panel_clk_q;
    assign panel_lat   = panel_lat_q;
    assign panel_oe_n  = panel_oe_n_q;
    assign panel_row   = panel_row_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// tb_fb_scan_ctrl: randomized bench for fb_scan_ctrl (COLS=4, ROWS=2).
// Expected waveforms come from a frame-offset model: each frame is a list of
// (row, plane) passes of 2*COLS shift + 2 latch + dwell cycles, and every
// output is derived arithmetically from the offset inside the current pass.
module tb_fb_scan_ctrl;

    localparam int C = 4;
    localparam int R = 2;
`ifdef FB_SCAN_BCM_EN
    localparam int P = 8;
    localparam int B = 1;
`else
    localparam int P = 1;
    localparam int B = 2;
`endif

    logic clk;
    logic rst;
    logic enable;
    logic panel_r, panel_g, panel_b, panel_clk, panel_lat, panel_oe_n;
    logic [2:0] panel_row;
    logic frame_start;

    fb_scan_ctrl_if fb_if ();

    fb_scan_ctrl #(
        .COLS       (C),
        .ROWS       (R),
        .PLANES     (8),
        .BASE_DWELL (B)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .enable      (enable),
        .fb          (fb_if),
        .panel_r     (panel_r),
        .panel_g     (panel_g),
        .panel_b     (panel_b),
        .panel_clk   (panel_clk),
        .panel_lat   (panel_lat),
        .panel_oe_n  (panel_oe_n),
        .panel_row   (panel_row),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two framebuffers, indexed [buffer][row][col].
    logic [7:0] mem_r [2][8][64];
    logic [7:0] mem_g [2][8][64];
    logic [7:0] mem_b [2][8][64];

    // Framebuffer read port: data one cycle after the address.
    always @(posedge clk) begin
        fb_if.red   <= mem_r[fb_if.display][fb_if.row][fb_if.col];
        fb_if.green <= mem_g[fb_if.display][fb_if.row][fb_if.col];
        fb_if.blue  <= mem_b[fb_if.display][fb_if.row][fb_if.col];
    end

    int n_vec  = 0;
    int n_miss = 0;
    int frame_len;

    bit         m_busy;
    int         m_t;
    bit         m_disp;
    bit         m_ack;
    bit         m_fs;
    int         m_prow;
    logic [2:0] m_pix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pass_len(input int p);
        return 2 * C + 2 + (B << p);
    endfunction

    function automatic int bit_of(input int p);
`ifdef FB_SCAN_BCM_EN
        return p;
`else
        return 7 + 0 * p;
`endif
    endfunction

    function automatic void decode(input int t, output int r, output int p, output int u);
        int acc = t;
        r = 0; p = 0; u = 0;
        for (int rr = 0; rr < R; rr++)
            for (int pp = 0; pp < P; pp++)
                if (acc >= 0) begin
                    if (acc < pass_len(pp)) begin
                        r = rr; p = pp; u = acc;
                    end
                    acc -= pass_len(pp);
                end
    endfunction

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_disp = 0; m_ack = 0; m_fs = 0;
        m_prow = 0; m_pix = '0;
    endtask

    task automatic model_advance(input bit en, input bit sreq);
        bit ack_n = 0;
        bit fs_n  = 0;
        int r, p, u, k, b;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (sreq) begin
                m_disp = ~m_disp; ack_n = 1;
            end else if (en) begin
                m_busy = 1; m_t = 0; fs_n = 1;
            end
        end else if (m_t == frame_len - 1) begin
            if (sreq) begin
                m_disp = ~m_disp; ack_n = 1;
            end
            m_t = 0;
            if (en) fs_n = 1;
            else    m_busy = 0;
        end else begin
            m_t++;
        end
        m_ack = ack_n;
        m_fs  = fs_n;
        if (m_busy) begin
            decode(m_t, r, p, u);
            if (u == 2 * C + 1) m_prow = r;
            if (u >= 2 && u <= 2 * C && (u % 2) == 0) begin
                k = (u - 2) / 2;
                b = bit_of(p);
                m_pix = {mem_r[m_disp][r][k][b], mem_g[m_disp][r][k][b], mem_b[m_disp][r][k][b]};
            end
        end
    endtask

    task automatic check_outputs();
        int r, p, u;
        int e_row = 0, e_col = 0;
        bit e_clk = 0, e_lat = 0, e_oe = 1;
        if (m_busy) begin
            decode(m_t, r, p, u);
            e_row = r;
            e_col = (u < 2 * C) ? u / 2 : 0;
            e_clk = (u >= 2 && u <= 2 * C && (u % 2) == 0);
            e_lat = (u == 2 * C + 1);
            e_oe  = !(u >= 2 * C + 2);
        end
        chk("row",         32'(fb_if.row),      32'(e_row));
        chk("col",         32'(fb_if.col),      32'(e_col));
        chk("display",     32'(fb_if.display),  32'(m_disp));
        chk("swap_ack",    32'(fb_if.swap_ack), 32'(m_ack));
        chk("frame_start", 32'(frame_start),    32'(m_fs));
        chk("panel_clk",   32'(panel_clk),      32'(e_clk));
        chk("panel_lat",   32'(panel_lat),      32'(e_lat));
        chk("panel_oe_n",  32'(panel_oe_n),     32'(e_oe));
        chk("panel_row",   32'(panel_row),      32'(m_prow));
        chk("panel_rgb",   32'({panel_r, panel_g, panel_b}), 32'(m_pix));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input int unsigned en_pct, input int unsigned swap_pct);
        check_outputs();
        if (fb_if.swap_req && fb_if.swap_ack)
            fb_if.swap_req = 1'b0;
        else if (!fb_if.swap_req && $urandom_range(0, 99) < swap_pct)
            fb_if.swap_req = 1'b1;
        enable = ($urandom_range(0, 99) < en_pct);
        @(posedge clk);
        model_advance(enable, fb_if.swap_req);
        @(negedge clk);
    endtask

    function automatic bit in_dwell();
        int r, p, u;
        decode(m_t, r, p, u);
        return m_busy && (u >= 2 * C + 2);
    endfunction

    initial begin
        logic [3:0] pat;
        bit hit;
        pat = 4'b1101;
        frame_len = 0;
        for (int pp = 0; pp < P; pp++) frame_len += pass_len(pp);
        frame_len *= R;

        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < 64; k++) begin
                    mem_r[d][r][k] = 8'($urandom);
                    mem_g[d][r][k] = 8'($urandom);
                    mem_b[d][r][k] = 8'($urandom);
                end
        // Buffer 0, row 0: red bit 7 reads 1,0,1,1 across the columns.
        for (int k = 0; k < C; k++) mem_r[0][0][k][7] = pat[k];

        rst = 1'b1;
        enable = 1'b0;
        fb_if.swap_req = 1'b0;
        model_reset();
        @(negedge clk);
        step(0, 0);
        rst = 1'b0;

        // Alternate busy stretches with mostly-idle stretches.
        for (int blk = 0; blk < 12; blk++)
            for (int i = 0; i < 300; i++)
                if (blk % 2 == 0) step(95, 3);
                else              step(30, 10);

        // Hit a dwell while showing buffer 1, then reset asynchronously.
        hit = 0;
        for (int i = 0; i < 20 * frame_len && !hit; i++) begin
            step(100, 5);
            hit = in_dwell() && m_disp;
        end
        chk("reach_dwell_buf1", 32'(hit), 32'd1);
        if (hit) begin
            #2 rst = 1'b1;
            #1;
            chk("async_oe_n",    32'(panel_oe_n),    32'd1);
            chk("async_display", 32'(fb_if.display), 32'd0);
            model_reset();
            @(negedge clk);
            rst = 1'b0;
        end
        for (int i = 0; i < 400; i++) step(90, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
